// File: rtl/avmm_mem_responder.sv
// Avalon-MM 64-bit slave memory: fixed-latency reads, byte-enabled writes, backdoor load/dump port.
// Define AVMM_MEM_RESPONDER_STATS_EN to add saturating rd_count/wr_count access counters.
module avmm_mem_responder #(
  parameter int          DEPTH        = 1024,
  parameter logic [63:0] BASE_ADDR    = 64'd0,
  parameter int          READ_LATENCY = 1,
  localparam int         IW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [63:0]   avmm_address,
  input  logic [7:0]    avmm_byteenable,
  input  logic          avmm_read,
  output logic [63:0]   avmm_readdata,
  input  logic          avmm_write,
  input  logic [63:0]   avmm_writedata,
  input  logic          bd_en,
  input  logic          bd_we,
  input  logic [IW-1:0] bd_index,
  input  logic [63:0]   bd_wdata,
  output logic [63:0]   bd_rdata,
  output logic          range_err,
  output logic          proto_err
`ifdef AVMM_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
`endif
);

  logic [63:0]   mem [DEPTH];
  logic [63:0]   offset;
  logic [60:0]   word_off;
  logic          addr_ok;
  logic          misaligned;
  logic          av_wr;
  logic          bd_ok;
  logic          bd_wr;
  logic [IW-1:0] av_idx;
  logic [63:0]   readdata_reg;
  logic [63:0]   bd_rdata_reg;
  logic          range_err_reg;
  logic          proto_err_reg;

  // Misaligned addresses are decoded as the aligned-down word.
  assign offset     = avmm_address - BASE_ADDR;
  assign word_off   = offset[63:3];
  assign misaligned = (offset[2:0] != 3'd0);
  assign addr_ok    = (avmm_address >= BASE_ADDR) && (word_off < 61'(DEPTH));
  assign av_idx     = word_off[IW-1:0];
  assign av_wr      = avmm_write && addr_ok && (avmm_byteenable != 8'd0);
  assign bd_ok      = ({1'b0, bd_index} < (IW + 1)'(DEPTH));
  // A backdoor write colliding with an Avalon write to the same word is dropped.
  assign bd_wr      = bd_en && bd_we && bd_ok && !(av_wr && (av_idx == bd_index));

  always_ff @(posedge clock) begin
    if (bd_wr)
      mem[bd_index] <= bd_wdata;
    if (av_wr)
      for (int b = 0; b < 8; b++)
        if (avmm_byteenable[b])
          mem[av_idx][8*b +: 8] <= avmm_writedata[8*b +: 8];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      bd_rdata_reg <= '0;
    else if (bd_en && !bd_we)
      bd_rdata_reg <= bd_ok ? mem[bd_index] : '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      range_err_reg <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      if ((avmm_read || avmm_write) && (!addr_ok || misaligned))
        range_err_reg <= 1'b1;
      if (avmm_read && avmm_write)
        proto_err_reg <= 1'b1;
    end
  end

  // The RAM read register is the first latency stage; readdata is the last.
  generate
    if (READ_LATENCY <= 1) begin : g_lat1
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
          readdata_reg <= '0;
        else if (avmm_read)
          readdata_reg <= addr_ok ? mem[av_idx] : '0;
      end
    end else begin : g_pipe
      localparam int PD = ((READ_LATENCY > 4) ? 4 : READ_LATENCY) - 1;
      logic [PD-1:0] vld_reg;
      logic [PD-1:0] oor_reg;
      logic [63:0]   data_reg [PD];

      always_ff @(posedge clock) begin
        if (avmm_read)
          data_reg[0] <= mem[av_idx];
        for (int i = 1; i < PD; i++)
          data_reg[i] <= data_reg[i-1];
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          vld_reg      <= '0;
          oor_reg      <= '0;
          readdata_reg <= '0;
        end else begin
          vld_reg[0] <= avmm_read;
          oor_reg[0] <= !addr_ok;
          for (int i = 1; i < PD; i++) begin
            vld_reg[i] <= vld_reg[i-1];
            oor_reg[i] <= oor_reg[i-1];
          end
          if (vld_reg[PD-1])
            readdata_reg <= oor_reg[PD-1] ? '0 : data_reg[PD-1];
        end
      end
    end
  endgenerate

  assign avmm_readdata = readdata_reg;
  assign bd_rdata      = bd_rdata_reg;
  assign range_err     = range_err_reg;
  assign proto_err     = proto_err_reg;

`ifdef AVMM_MEM_RESPONDER_STATS_EN
  logic [31:0] rd_count_reg;
  logic [31:0] wr_count_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (avmm_read && (rd_count_reg != 32'hFFFF_FFFF))
        rd_count_reg <= rd_count_reg + 32'd1;
      if (avmm_write && (wr_count_reg != 32'hFFFF_FFFF))
        wr_count_reg <= wr_count_reg + 32'd1;
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Directed-vector bench for avmm_mem_responder: one READ_LATENCY=1 and one READ_LATENCY=3 instance
// share all inputs; each table row is one clock cycle with expected outputs sampled on the falling edge.
module tb_avmm_mem_responder;

  localparam logic [63:0] B  = 64'h1000;
  localparam logic [63:0] AB = 64'hAAAAAAAABBBBBBBB;
  localparam logic [63:0] M2 = 64'hAAAAAAAA55667788;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        bden;
    logic        bdwe;
    logic [3:0]  bdi;
    logic [63:0] bdw;
    logic [63:0] e_rd1;
    logic [63:0] e_rd3;
    logic [63:0] e_bd;
    logic        e_re;
    logic        e_pe;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] avmm_address = '0;
  logic [7:0]  avmm_byteenable = '0;
  logic        avmm_read = 1'b0;
  logic        avmm_write = 1'b0;
  logic [63:0] avmm_writedata = '0;
  logic        bd_en = 1'b0;
  logic        bd_we = 1'b0;
  logic [3:0]  bd_index = '0;
  logic [63:0] bd_wdata = '0;

  logic [63:0] rdata1, rdata3, bdr1, bdr3;
  logic        rerr1, rerr3, perr1, perr3;
`ifdef AVMM_MEM_RESPONDER_STATS_EN
  logic [31:0] rdc1, wrc1, rdc3, wrc3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  avmm_mem_responder #(.DEPTH(16), .BASE_ADDR(B), .READ_LATENCY(1)) u_lat1 (
    .clock(clock), .resetn(resetn),
    .avmm_address(avmm_address), .avmm_byteenable(avmm_byteenable),
    .avmm_read(avmm_read), .avmm_readdata(rdata1),
    .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
    .bd_en(bd_en), .bd_we(bd_we), .bd_index(bd_index), .bd_wdata(bd_wdata),
    .bd_rdata(bdr1), .range_err(rerr1), .proto_err(perr1)
`ifdef AVMM_MEM_RESPONDER_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1)
`endif
  );

  avmm_mem_responder #(.DEPTH(16), .BASE_ADDR(B), .READ_LATENCY(3)) u_lat3 (
    .clock(clock), .resetn(resetn),
    .avmm_address(avmm_address), .avmm_byteenable(avmm_byteenable),
    .avmm_read(avmm_read), .avmm_readdata(rdata3),
    .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
    .bd_en(bd_en), .bd_we(bd_we), .bd_index(bd_index), .bd_wdata(bd_wdata),
    .bd_rdata(bdr3), .range_err(rerr3), .proto_err(perr3)
`ifdef AVMM_MEM_RESPONDER_STATS_EN
    , .rd_count(rdc3), .wr_count(wrc3)
`endif
  );

  function automatic vec_t mk(input logic rd, input logic wr, input logic [63:0] addr,
                              input logic [7:0] be, input logic [63:0] wdata,
                              input logic bden, input logic bdwe, input logic [3:0] bdi,
                              input logic [63:0] bdw, input logic [63:0] e_rd1,
                              input logic [63:0] e_rd3, input logic [63:0] e_bd,
                              input logic e_re, input logic e_pe);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
    v.bden = bden; v.bdwe = bdwe; v.bdi = bdi; v.bdw = bdw;
    v.e_rd1 = e_rd1; v.e_rd3 = e_rd3; v.e_bd = e_bd; v.e_re = e_re; v.e_pe = e_pe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    avmm_read = 1'b0; avmm_write = 1'b0; avmm_address = '0; avmm_byteenable = '0;
    avmm_writedata = '0; bd_en = 1'b0; bd_we = 1'b0; bd_index = '0; bd_wdata = '0;
  endtask

  // Called on a falling edge: drive one cycle of inputs, then check on the next falling edge.
  task automatic run_vec(input vec_t v, input string tag, input int idx);
    avmm_read = v.rd; avmm_write = v.wr; avmm_address = v.addr; avmm_byteenable = v.be;
    avmm_writedata = v.wdata; bd_en = v.bden; bd_we = v.bdwe; bd_index = v.bdi; bd_wdata = v.bdw;
    @(negedge clock);
    $display("%s%0d: rd=%b wr=%b addr=%h be=%h bd=%b%b[%0d] -> rd1=%h rd3=%h bd=%h re=%b pe=%b",
             tag, idx, v.rd, v.wr, v.addr, v.be, v.bden, v.bdwe, v.bdi, rdata1, rdata3, bdr1,
             rerr1, perr1);
    chk($sformatf("%s%0d.readdata_l1", tag, idx), rdata1, v.e_rd1);
    chk($sformatf("%s%0d.readdata_l3", tag, idx), rdata3, v.e_rd3);
    chk($sformatf("%s%0d.bd_rdata", tag, idx), bdr1, v.e_bd);
    chk($sformatf("%s%0d.bd_rdata_l3", tag, idx), bdr3, v.e_bd);
    chk($sformatf("%s%0d.range_err", tag, idx), {63'd0, rerr1}, {63'd0, v.e_re});
    chk($sformatf("%s%0d.range_err_l3", tag, idx), {63'd0, rerr3}, {63'd0, v.e_re});
    chk($sformatf("%s%0d.proto_err", tag, idx), {63'd0, perr1}, {63'd0, v.e_pe});
    chk($sformatf("%s%0d.proto_err_l3", tag, idx), {63'd0, perr3}, {63'd0, v.e_pe});
  endtask

  vec_t t1 [24];
  vec_t t2 [10];

  initial begin
    //              rd wr addr    be     wdata                  bden bdwe bdi bdw     e_rd1 e_rd3 e_bd  re pe
    t1[0]  = mk(0, 0, 64'd0,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd0, 64'd0, 64'd0, 0, 0);
    t1[1]  = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 1, 4'd0, 64'd5,  64'd0, 64'd0, 64'd0, 0, 0);
    t1[2]  = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 1, 4'd1, 64'd3,  64'd0, 64'd0, 64'd0, 0, 0);
    t1[3]  = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 1, 4'd2, 64'd8,  64'd0, 64'd0, 64'd0, 0, 0);
    t1[4]  = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 1, 4'd3, 64'd1,  64'd0, 64'd0, 64'd0, 0, 0);
    t1[5]  = mk(1, 0, B,      8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd5, 64'd0, 64'd0, 0, 0);
    t1[6]  = mk(1, 0, B+8,    8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd3, 64'd0, 64'd0, 0, 0);
    t1[7]  = mk(1, 0, B+16,   8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd8, 64'd5, 64'd0, 0, 0);
    t1[8]  = mk(1, 0, B+24,   8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd1, 64'd3, 64'd0, 0, 0);
    t1[9]  = mk(0, 0, 64'd0,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd1, 64'd8, 64'd0, 0, 0);
    t1[10] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd1, 64'd1, 64'd0, 0, 0);
    t1[11] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd1, 64'd1, 64'd0, 0, 0);
    t1[12] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 1, 4'd2, AB,     64'd1, 64'd1, 64'd0, 0, 0);
    t1[13] = mk(0, 1, B+16,   8'h0F, 64'h1122334455667788,  1, 0, 4'd2, 64'd0,  64'd1, 64'd1, AB,    0, 0);
    t1[14] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 0, 4'd2, 64'd0,  64'd1, 64'd1, M2,    0, 0);
    t1[15] = mk(1, 1, B+8,    8'hFF, 64'd9,                 0, 0, 4'd0, 64'd0,  64'd3, 64'd1, M2,    0, 1);
    t1[16] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 0, 4'd1, 64'd0,  64'd3, 64'd1, 64'd9, 0, 1);
    t1[17] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd3, 64'd3, 64'd9, 0, 1);
    t1[18] = mk(1, 0, B+128,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd0, 64'd3, 64'd9, 1, 1);
    t1[19] = mk(0, 1, B+128,  8'hFF, 64'hFFFFFFFFFFFFFFFF,  0, 0, 4'd0, 64'd0,  64'd0, 64'd3, 64'd9, 1, 1);
    t1[20] = mk(0, 1, B+24,   8'hFF, 64'h77,                1, 1, 4'd3, 64'h66, 64'd0, 64'd0, 64'd9, 1, 1);
    t1[21] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 0, 4'd3, 64'd0,  64'd0, 64'd0, 64'h77, 1, 1);
    t1[22] = mk(1, 0, B-8,    8'h00, 64'd0,                 0, 0, 4'd0, 64'd0,  64'd0, 64'd0, 64'h77, 1, 1);
    t1[23] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 0, 4'd0, 64'd0,  64'd0, 64'd0, 64'd5, 1, 1);

    t2[0] = mk(0, 1, B,      8'h00, 64'hFFFFFFFFFFFFFFFF,  0, 0, 4'd0, 64'd0, 64'd0,  64'd0,  64'd0,  0, 0);
    t2[1] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 1, 0, 4'd0, 64'd0, 64'd0,  64'd0,  64'd5,  0, 0);
    t2[2] = mk(1, 0, B+9,    8'h00, 64'd0,                 0, 0, 4'd0, 64'd0, 64'd9,  64'd0,  64'd5,  1, 0);
    t2[3] = mk(1, 0, B,      8'h00, 64'd0,                 0, 0, 4'd0, 64'd0, 64'd5,  64'd0,  64'd5,  1, 0);
    t2[4] = mk(1, 0, B+24,   8'h00, 64'd0,                 1, 0, 4'd3, 64'd0, 64'h77, 64'd9,  64'h77, 1, 0);
    t2[5] = mk(1, 0, B+16,   8'h00, 64'd0,                 0, 0, 4'd0, 64'd0, M2,     64'd5,  64'h77, 1, 0);
    t2[6] = mk(0, 1, B+24,   8'h01, 64'h12,                1, 0, 4'd1, 64'd0, M2,     64'h77, 64'd9,  1, 0);
    t2[7] = mk(1, 0, B+24,   8'h00, 64'd0,                 0, 0, 4'd0, 64'd0, 64'h12, M2,     64'd9,  1, 0);
    t2[8] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0, 64'h12, M2,     64'd9,  1, 0);
    t2[9] = mk(0, 0, 64'd0,  8'h00, 64'd0,                 0, 0, 4'd0, 64'd0, 64'h12, 64'h12, 64'd9,  1, 0);

    drive_idle();
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 24; i++) run_vec(t1[i], "t1_", i);

    // Reset asserted between clock edges while a read is in flight in the latency-3 pipe.
    avmm_read = 1'b1; avmm_address = B;
    @(negedge clock);
    drive_idle();
    chk("pre_reset.readdata_l1", rdata1, 64'd5);
    #2 resetn = 1'b0;
    #1;
    $display("async reset: rd1=%h rd3=%h bd=%h re=%b pe=%b", rdata1, rdata3, bdr1, rerr1, perr1);
    chk("async_reset.readdata_l1", rdata1, 64'd0);
    chk("async_reset.readdata_l3", rdata3, 64'd0);
    chk("async_reset.bd_rdata", bdr1, 64'd0);
    chk("async_reset.range_err", {63'd0, rerr1}, 64'd0);
    chk("async_reset.proto_err", {63'd0, perr1}, 64'd0);
    chk("async_reset.proto_err_l3", {63'd0, perr3}, 64'd0);
    @(negedge clock);
    resetn = 1'b1;
`ifdef AVMM_MEM_RESPONDER_STATS_EN
    chk("reset.rd_count", {32'd0, rdc1}, 64'd0);
    chk("reset.wr_count", {32'd0, wrc1}, 64'd0);
`endif

    for (int i = 0; i < 10; i++) run_vec(t2[i], "t2_", i);

`ifdef AVMM_MEM_RESPONDER_STATS_EN
    $display("stats: rd_count=%0d wr_count=%0d", rdc1, wrc1);
    chk("stats.rd_count", {32'd0, rdc1}, 64'd5);
    chk("stats.wr_count", {32'd0, wrc1}, 64'd2);
    chk("stats.rd_count_l3", {32'd0, rdc3}, 64'd5);
    chk("stats.wr_count_l3", {32'd0, wrc3}, 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avmm_mem_responder.md
Name: avmm_mem_responder

Overview:
- Avalon-MM slave memory that answers the 64-bit read/write master port of our HLS sort components (avmm_0_rw style: address, byteenable, read, readdata, write, writedata; no waitrequest, no readdatavalid).
- Provides fixed-latency reads, byte-enabled writes and a backdoor load/dump port, so benches and top-level wrappers can preload an array, run the component and check the result in place.

Parameters:
- DEPTH, 1024, number of 64-bit words
- BASE_ADDR, 0, byte address mapped to word 0
- READ_LATENCY, 1, cycles from read accept to readdata valid (legal range 1..4)

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- avmm_address  in  64  byte address from master
- avmm_byteenable  in  8  per-byte write enable
- avmm_read  in  1  read request
- avmm_readdata  out  64  read response data
- avmm_write  in  1  write request
- avmm_writedata  in  64  write data
- bd_en  in  1  backdoor access strobe
- bd_we  in  1  backdoor write (1) / read (0)
- bd_index  in  clog2(DEPTH)  backdoor word index
- bd_wdata  in  64  backdoor write data
- bd_rdata  out  64  backdoor read data, 1-cycle latency
- range_err  out  1  sticky out-of-range or misaligned access flag
- proto_err  out  1  sticky read-and-write-same-cycle flag

Behaviour:
- Reset: async assert on resetn low. avmm_readdata=0, bd_rdata=0, range_err=0, proto_err=0, latency pipe cleared. Memory contents are not cleared.
- Decode:
  - offset = address − BASE_ADDR; word index = offset[.. :3].
  - In range iff address ≥ BASE_ADDR and index < DEPTH.
  - offset[2:0] ≠ 0 → misaligned: range_err set, address treated as aligned down.
- Write: every cycle avmm_write=1 is accepted (slave never stalls).
  - In range: for each b where byteenable[b]=1, byte b of the word takes writedata[8b+7:8b]. Other bytes are kept.
  - Out of range: dropped, range_err set.
  - byteenable=0: no change, no error.
- Read: every cycle avmm_read=1 is accepted.
  - The word is sampled in the accept cycle (read-before-write on a same-cycle collision).
  - avmm_readdata is updated exactly READ_LATENCY cycles later and holds until the next read result lands.
  - Out of range: returns 0 and sets range_err.
  - Back-to-back reads give one result per cycle, in order.
- Latency pipe: READ_LATENCY-deep valid/data shift register. The final stage loads avmm_readdata when valid.
- read and write in the same cycle:
  - proto_err set; the write is performed.
  - The read returns pre-write data for that address.
- Backdoor port:
  - bd_en & bd_we writes a full word.
  - bd_en & ~bd_we loads bd_rdata next cycle.
  - Same-cycle Avalon and backdoor writes to the same word: Avalon wins.
  - Backdoor reads see data written in earlier cycles only.
- Error flags are sticky until resetn.
- Reset mid-read: in-flight reads are discarded; readdata stays 0 until a new read completes.
- Memory is inferred as simple dual-port RAM plus registers. No combinational path from inputs to outputs.

Optional Feature:
- Macro AVMM_MEM_RESPONDER_STATS_EN.
- Defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0], counting accepted Avalon reads/writes including out-of-range ones; backdoor accesses are not counted.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent. All other behaviour is identical.

Test Plan:
- Reset then backdoor preload words 0..3 = 5,3,8,1. Avalon read of address BASE+8 with READ_LATENCY=1 → readdata=3 one cycle later; readdata=0 before that.
- Write 0x1122334455667788 to index 2 with byteenable=0x0F over existing 0xAAAAAAAABBBBBBBB → backdoor read returns 0xAAAAAAAA55667788.
- READ_LATENCY=3, reads on 4 consecutive cycles to indices 0..3 (preloaded 5,3,8,1) → readdata = 5,3,8,1 on cycles 3..6 after the first read; held at 1 afterwards.
- Read and write of index 1 in the same cycle, writedata=9 with old value 3 → readdata=3, memory=9, proto_err=1 and stays 1.
- Read at BASE+8·DEPTH → readdata=0 and range_err=1. Write there → no memory word changes. Assert resetn low mid-pipe → flags and readdata return to 0 asynchronously.
- With AVMM_MEM_RESPONDER_STATS_EN: 5 reads, 2 writes, 3 backdoor ops → rd_count=5, wr_count=2.
